alu_exec_sequencer: RTL

//  Execute-stage controller in front of the combinational ALU. Accepts one op per

---
 rtl/alu_exec_pkg.sv | 17 +
 rtl/alu_exec_sequencer_mul_core.sv | 55 +++++
 rtl/alu_exec_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/alu_exec_pkg.sv
// Shared opcodes and controller state encoding for the execute-stage sequencer.
package alu_exec_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_exec_sequencer_mul_core.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per step, LSB first.
// The counter must be wide enough that 2**CNT_W > WIDTH.
module shift_add_mul_core #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 step,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 last,
    output logic [2*WIDTH-1:0]   acc_next
);
    import alu_exec_pkg::*;

    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]   count_q;

    // The step currently being processed is the final one.
    assign last = (count_q == CNT_W'(WIDTH - 1));

    // Value the accumulator takes after this step; exposed so the final product
    // can be captured on the same edge that performs the last addition.
    assign acc_next = mplier_q[0] ? (acc_q + ({{WIDTH{1'b0}}, mcand_q} << count_q)) : acc_q;

    // Operand/accumulator registers: clear beats start, start beats step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else if (clear) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            count_q  <= '0;
        end else if (step) begin
            acc_q    <= acc_next;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/alu_exec_sequencer.sv
// Execute-stage controller: routes ops to the external combinational ALU or the
// internal multiplier, and presents one held response per accepted op.
module alu_exec_sequencer
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_ctrl,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    output logic             busy
);

    state_e             state_q, state_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic               rsp_overflow_q, rsp_overflow_d;
    logic [3:0]         ctrl_q, ctrl_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               mul_start;
    logic               mul_step;
    logic               mul_last;
    logic [2*WIDTH-1:0] mul_acc_next;

    shift_add_mul_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk      (clk),
        .rst      (rst),
        .start    (mul_start),
        .step     (mul_step),
        .clear    (flush),
        .a        (req_a),
        .b        (req_b),
        .last     (mul_last),
        .acc_next (mul_acc_next)
    );

    // Next-state, response capture and multiplier control; flush overrides everything.
    always_comb begin
        state_d        = state_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_result_d   = rsp_result_q;
        rsp_overflow_d = rsp_overflow_q;
        ctrl_d         = ctrl_q;
        a_d            = a_q;
        b_d            = b_q;
        mul_start      = 1'b0;
        mul_step       = 1'b0;
        if (flush) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        ctrl_d = req_ctrl;
                        a_d    = req_a;
                        b_d    = req_b;
                        if (req_ctrl == ALU_MUL) begin
                            mul_start = 1'b1;
                            state_d   = MUL;
                        end else begin
                            rsp_result_d   = alu_result;
                            rsp_overflow_d = alu_overflow;
                            rsp_valid_d    = 1'b1;
                            state_d        = DONE;
                        end
                    end
                end
                MUL: begin
                    mul_step = 1'b1;
                    if (mul_last) begin
                        rsp_result_d   = mul_acc_next[WIDTH-1:0];
                        rsp_overflow_d = |mul_acc_next[2*WIDTH-1:WIDTH];
                        rsp_valid_d    = 1'b1;
                        state_d        = DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, response and held-request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            rsp_valid_q    <= 1'b0;
            rsp_result_q   <= '0;
            rsp_overflow_q <= 1'b0;
            ctrl_q         <= '0;
            a_q            <= '0;
            b_q            <= '0;
        end else begin
            state_q        <= state_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_result_q   <= rsp_result_d;
            rsp_overflow_q <= rsp_overflow_d;
            ctrl_q         <= ctrl_d;
            a_q            <= a_d;
            b_q            <= b_d;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    // In IDLE the ALU sees the live request so its result is ready at the accept edge.
    assign alu_ctrl     = (state_q == IDLE) ? req_ctrl : ctrl_q;
    assign alu_a        = (state_q == IDLE) ? req_a    : a_q;
    assign alu_b        = (state_q == IDLE) ? req_b    : b_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_overflow = rsp_overflow_q;
    // Qualified by rsp_valid so every response output reads 0 out of reset.
    assign rsp_zero     = rsp_valid_q && (rsp_result_q == '0);

endmodule
